// File: rtl/native_port_pkg.sv
// Purpose: shared widths, FSM state encoding and command record for the native-port responder.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package native_port_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 27;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RDMEM = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

endpackage

// File: rtl/native_sram_1rw.sv
// Purpose: single-port DEPTH x DATA_W scratchpad with byte-enabled writes; drop-in slot for a vendor macro.
// Latency: write lands at the strobe edge; read data is registered, valid one cycle after the read strobe.
// Backpressure: none; caller guarantees at most one of we/re per cycle.
module native_sram_1rw #(
    parameter int  DEPTH  = 64,
    parameter int  DATA_W = 256,
    localparam int AW     = $clog2(DEPTH),
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port; output holds its value between read strobes.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/native_port_responder.sv
// Purpose: native-port slave terminating single-beat cmd/wdata/rdata channels against an SRAM scratchpad.
// Latency: write 2 cycles min (cmd, wdata); read 3 cycles min (cmd, SRAM access, response).
// Backpressure: one command outstanding; cmd_ready low until the transaction retires; response held until rdata_ready.
module native_port_responder
    import native_port_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_first,
    input  logic              cmd_last,
    input  logic              cmd_payload_we,
    input  logic [ADDR_W-1:0] cmd_payload_addr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic              wdata_first,
    input  logic              wdata_last,
    input  logic [DATA_W-1:0] wdata_payload_data,
    input  logic [MASK_W-1:0] wdata_payload_we,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              rdata_first,
    output logic              rdata_last,
    output logic [DATA_W-1:0] rdata_payload_data,
    output logic              addr_err,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int                MEM_AW  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state_q, state_d;
    cmd_t              cmd_in, cmd_q;
    logic              oor_q;
    logic              cmd_rdy_q;
    logic              cmd_hs, wd_hs, rd_hs, cmd_oor;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_ok;

    assign cmd_in  = '{we: cmd_payload_we, addr: cmd_payload_addr};
    assign cmd_oor = (cmd_payload_addr >= DEPTH_A);

    // cmd_ready is a flop so enable never reaches it combinationally; enable therefore acts one cycle late.
    assign cmd_ready   = cmd_rdy_q;
    assign wdata_ready = (state_q == WDATA);
    assign rdata_valid = (state_q == RESP);
    assign rdata_first = rdata_valid;
    assign rdata_last  = rdata_valid;
    // Out-of-range reads and idle cycles present zeros instead of stale SRAM output.
    assign rdata_payload_data = (rdata_valid && !oor_q) ? mem_rdata : '0;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign wd_hs  = wdata_valid & wdata_ready;
    assign rd_hs  = rdata_valid & rdata_ready;

    // Single-beat protocol: framing bits and upper address bits carry no information here.
    assign unused_ok = &{1'b0, cmd_first, cmd_last, wdata_first, wdata_last,
                         cmd_q.we, cmd_q.addr[ADDR_W-1:MEM_AW]};

    // Next-state and SRAM strobes; clr_i overrides every handshake.
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_payload_we ? WDATA : RDMEM;
            WDATA:   if (wd_hs) begin
                         mem_we  = !oor_q;
                         state_d = IDLE;
                     end
            RDMEM:   begin
                         mem_re  = !oor_q;
                         state_d = RESP;
                     end
            RESP:    if (rd_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
            mem_we  = 1'b0;
            mem_re  = 1'b0;
        end
    end

    // State, ready flop and captured command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_rdy_q <= 1'b0;
            cmd_q     <= '0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= (state_d == IDLE) && enable && !clr_i;
            if (cmd_hs && !clr_i) begin
                cmd_q <= cmd_in;
                oor_q <= cmd_oor;
            end
        end
    end

    // Completion counters and sticky range error; clr_i wins over same-cycle completions.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            addr_err <= 1'b0;
        end else begin
            if (wd_hs)            wr_cnt   <= wr_cnt + 16'd1;
            if (rd_hs)            rd_cnt   <= rd_cnt + 16'd1;
            if (cmd_hs && cmd_oor) addr_err <= 1'b1;
        end
    end

    native_sram_1rw #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (cmd_q.addr[MEM_AW-1:0]),
        .wdata (wdata_payload_data),
        .wmask (wdata_payload_we),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_native_port_responder.sv
// Purpose: directed self-checking bench for native_port_responder.
// Latency: n/a.
// Backpressure: exercises rdata_ready stalls and enable gating.
module tb_native_port_responder;
    import native_port_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr_i = 1'b0;
    logic              enable = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_first = 1'b0;
    logic              cmd_last = 1'b0;
    logic              cmd_payload_we = 1'b0;
    logic [ADDR_W-1:0] cmd_payload_addr = '0;
    logic              wdata_valid = 1'b0;
    logic              wdata_ready;
    logic              wdata_first = 1'b0;
    logic              wdata_last = 1'b0;
    logic [DATA_W-1:0] wdata_payload_data = '0;
    logic [MASK_W-1:0] wdata_payload_we = '0;
    logic              rdata_valid;
    logic              rdata_ready = 1'b0;
    logic              rdata_first;
    logic              rdata_last;
    logic [DATA_W-1:0] rdata_payload_data;
    logic              addr_err;
    logic [15:0]       wr_cnt;
    logic [15:0]       rd_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] pat_a5, pat_ones, pat_11, pat_77, pat_merge, zero_v;

    always #5 clk = ~clk;

    native_port_responder #(.DEPTH(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .clr_i              (clr_i),
        .enable             (enable),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_first          (cmd_first),
        .cmd_last           (cmd_last),
        .cmd_payload_we     (cmd_payload_we),
        .cmd_payload_addr   (cmd_payload_addr),
        .wdata_valid        (wdata_valid),
        .wdata_ready        (wdata_ready),
        .wdata_first        (wdata_first),
        .wdata_last         (wdata_last),
        .wdata_payload_data (wdata_payload_data),
        .wdata_payload_we   (wdata_payload_we),
        .rdata_valid        (rdata_valid),
        .rdata_ready        (rdata_ready),
        .rdata_first        (rdata_first),
        .rdata_last         (rdata_last),
        .rdata_payload_data (rdata_payload_data),
        .addr_err           (addr_err),
        .wr_cnt             (wr_cnt),
        .rd_cnt             (rd_cnt)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until cmd_ready is seen high at a falling edge.
    task automatic wait_cmd_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, DATA_W'(cmd_ready), DATA_W'(1));
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_payload_we = 1'b1; cmd_payload_addr = a;
        wait_cmd_ready("wr_cmd_ready");
        @(posedge clk); #1;
        cmd_valid = 1'b0; wdata_valid = 1'b1; wdata_payload_data = d; wdata_payload_we = m;
        @(negedge clk);
        check("wr_wdata_ready", DATA_W'(wdata_ready), DATA_W'(1));
        @(posedge clk); #1;
        wdata_valid = 1'b0;
        @(negedge clk);
        check("wr_done_wdata_ready", DATA_W'(wdata_ready), DATA_W'(0));
        check("wr_done_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input int stall);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_payload_we = 1'b0; cmd_payload_addr = a;
        wait_cmd_ready("rd_cmd_ready");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rd_rdmem_valid", DATA_W'(rdata_valid), DATA_W'(0));
        @(posedge clk);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", DATA_W'(rdata_valid), DATA_W'(1));
            check("stall_data", rdata_payload_data, exp);
            check("stall_cmd_ready", DATA_W'(cmd_ready), DATA_W'(0));
            @(posedge clk);
        end
        #1 rdata_ready = 1'b1;
        @(negedge clk);
        check("rd_valid", DATA_W'(rdata_valid), DATA_W'(1));
        check("rd_first_last", DATA_W'({rdata_first, rdata_last}), DATA_W'(2'b11));
        check("rd_data", rdata_payload_data, exp);
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        @(negedge clk);
        check("rd_done_valid", DATA_W'(rdata_valid), DATA_W'(0));
        check("rd_done_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));
    endtask

    initial begin
        pat_a5    = {32{8'hA5}};
        pat_ones  = '1;
        pat_11    = {32{8'h11}};
        pat_77    = {32{8'h77}};
        pat_merge = {{224{1'b1}}, 32'h0};
        zero_v    = '0;

        // Reset: everything low while asserted and for the first cycle after.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", DATA_W'(cmd_ready), zero_v);
        check("rst_outputs", DATA_W'({wdata_ready, rdata_valid, rdata_first, rdata_last, addr_err}), zero_v);
        check("rst_data", rdata_payload_data, zero_v);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", DATA_W'(cmd_ready), zero_v);
        check("post_rst_cnts", DATA_W'({wr_cnt, rd_cnt}), zero_v);
        @(negedge clk);
        check("post_rst2_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));

        // Basic write then read.
        do_write(27'd5, pat_a5, '1);
        do_read(27'd5, pat_a5, 0);
        check("cnt_wr_1", DATA_W'(wr_cnt), DATA_W'(16'd1));
        check("cnt_rd_1", DATA_W'(rd_cnt), DATA_W'(16'd1));

        // Byte-mask merge.
        do_write(27'd3, pat_ones, '1);
        do_write(27'd3, zero_v, 32'h0000_000F);
        do_read(27'd3, pat_merge, 0);
        check("cnt_wr_3", DATA_W'(wr_cnt), DATA_W'(16'd3));

        // Response held across a 10-cycle rdata_ready stall.
        do_read(27'd5, pat_a5, 10);
        check("cnt_rd_3", DATA_W'(rd_cnt), DATA_W'(16'd3));
        check("no_err_yet", DATA_W'(addr_err), zero_v);

        // Out-of-range read: zeros, sticky error, still counted.
        do_read(27'd64, zero_v, 0);
        check("oor_err", DATA_W'(addr_err), DATA_W'(1));
        check("oor_rd_cnt", DATA_W'(rd_cnt), DATA_W'(16'd4));
        do_read(27'd3, pat_merge, 0);
        check("oor_err_sticky", DATA_W'(addr_err), DATA_W'(1));

        // clr_i coincident with a wdata handshake.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_payload_we = 1'b1; cmd_payload_addr = 27'd5;
        wait_cmd_ready("clr_cmd_ready");
        @(posedge clk); #1;
        cmd_valid = 1'b0; wdata_valid = 1'b1; wdata_payload_data = pat_11; wdata_payload_we = '1; clr_i = 1'b1;
        @(negedge clk);
        check("clr_wdata_ready", DATA_W'(wdata_ready), DATA_W'(1));
        @(posedge clk); #1;
        clr_i = 1'b0; wdata_valid = 1'b0;
        @(negedge clk);
        check("clr_idle", DATA_W'({wdata_ready, rdata_valid, cmd_ready}), zero_v);
        check("clr_cnts", DATA_W'({wr_cnt, rd_cnt}), zero_v);
        check("clr_err", DATA_W'(addr_err), zero_v);
        @(negedge clk);
        check("clr_cmd_ready_back", DATA_W'(cmd_ready), DATA_W'(1));
        do_read(27'd5, pat_a5, 0);
        check("clr_rd_cnt", DATA_W'(rd_cnt), DATA_W'(16'd1));
        check("clr_wr_cnt", DATA_W'(wr_cnt), zero_v);

        // enable gating.
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_payload_we = 1'b1; cmd_payload_addr = 27'd7;
        repeat (4) begin
            @(negedge clk);
            check("en_low_cmd_ready", DATA_W'(cmd_ready), zero_v);
            check("en_low_wdata_ready", DATA_W'(wdata_ready), zero_v);
        end
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        check("en_rise_cmd_ready", DATA_W'(cmd_ready), zero_v);
        @(negedge clk);
        check("en_next_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0; wdata_valid = 1'b1; wdata_payload_data = pat_77; wdata_payload_we = '1;
        @(negedge clk);
        check("en_wdata_ready", DATA_W'(wdata_ready), DATA_W'(1));
        @(posedge clk); #1 wdata_valid = 1'b0;
        @(negedge clk);
        check("en_wr_cnt", DATA_W'(wr_cnt), DATA_W'(16'd1));
        do_read(27'd7, pat_77, 0);
        check("final_rd_cnt", DATA_W'(rd_cnt), DATA_W'(16'd2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/native_port_responder.md
# native_port_responder

Native-port slave that terminates the crossbar-side native command/write-data/read-data channels against a single-port SRAM scratchpad. It is the responder counterpart of the DLA native-port master adaptor. Each command is single-beat. Writes honour per-byte masks. Reads return one beat with a fixed one-cycle memory latency. It provides a self-contained memory endpoint for bring-up and for verifying the master path without the LPDDR4 controller.

## Interface
- DATA_W, 256: data beat width in bits; byte-mask width is DATA_W/8.
- ADDR_W, 27: native command address width, in beat (word) units.
- DEPTH, 64: SRAM depth in beats; power of two; MEM_AW = log2(DEPTH).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- clr_i  in  1  synchronous abort; returns FSM to IDLE and clears counters and error.
- enable  in  1  block enable; when low, no new command is accepted.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_first, cmd_last  in  1  ignored; single-beat protocol.
- cmd_payload_we  in  1  1 = write, 0 = read.
- cmd_payload_addr  in  ADDR_W  beat address.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted.
- wdata_first, wdata_last  in  1  ignored.
- wdata_payload_data  in  DATA_W  write data.
- wdata_payload_we  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- rdata_valid  out  1  read beat valid.
- rdata_ready  in  1  read beat consumed.
- rdata_first, rdata_last  out  1  both equal rdata_valid (single beat).
- rdata_payload_data  out  DATA_W  read data.
- addr_err  out  1  sticky; set by any out-of-range command.
- wr_cnt, rd_cnt  out  16 each  completed writes / reads; wrap at 16'hFFFF→0.

## Operation
- States: IDLE, WDATA, RDMEM, RESP.
- IDLE:
  - cmd_ready = enable.
  - On cmd handshake, register addr and we.
  - we=1 → WDATA; we=0 → RDMEM.
- WDATA:
  - wdata_ready = 1.
  - On wdata handshake, write SRAM at addr[MEM_AW-1:0] with byte mask, increment wr_cnt, go to IDLE.
- RDMEM:
  - SRAM read strobe asserted for one cycle; unconditionally go to RESP.
- RESP:
  - rdata_valid = 1; data held stable until rdata_ready.
  - On handshake, increment rd_cnt, go to IDLE.
- Out of range (addr >= DEPTH):
  - Set addr_err.
  - Write: the wdata beat is still handshaked but discarded, and wr_cnt still increments.
  - Read: returns all zeros; rd_cnt still increments.
- wdata_valid outside WDATA: ignored (wdata_ready = 0). rdata_ready outside RESP: ignored.
- clr_i has priority over all handshakes in the same cycle:
  - State → IDLE; outputs deassert next cycle.
  - A coincident wdata handshake performs no SRAM write.
  - A coincident rdata handshake does not count.
  - wr_cnt, rd_cnt and addr_err → 0.
- enable low mid-transaction: the current transaction completes; only IDLE acceptance is gated.
- SRAM contents are not reset. Reading unwritten locations is X in simulation; the bench must write before reading.

## Timing
- During reset and in the first cycle after it: every output is 0 (cmd_ready, wdata_ready, rdata_valid/first/last, rdata_payload_data, addr_err, wr_cnt, rd_cnt). From the following cycle, cmd_ready = enable.
- Write: command handshake at cycle T → wdata_ready from T+1 → wdata handshake at W ≥ T+1 → SRAM updated at the W edge → cmd_ready at W+1. Minimum 2 cycles per write.
- Read: command handshake at T → RDMEM at T+1 → rdata_valid at T+2 → handshake at R ≥ T+2 → cmd_ready at R+1. Minimum 3 cycles per read.
- Read-after-write: a read accepted at W+1 or later returns the merged (masked) data.
- All outputs are registered or decoded directly from state; no combinational path from any input to any ready/valid output.
- One outstanding command at most; no interleaving.

## Structure
- Package native_port_pkg:
  - state enum {IDLE, WDATA, RDMEM, RESP};
  - DATA_W, ADDR_W and byte-mask width constants;
  - command-field typedef {we, addr}.
- Sub-module native_sram_1rw (DEPTH × DATA_W):
  - single port, synchronous write with byte enables;
  - registered read data, 1-cycle latency;
  - swappable for a vendor macro.
- Top: FSM, command register, response register, counters and error flag.

## Test plan
- Full-mask write addr 5 data 0xA5..A5, then read addr 5 → rdata_valid at T+2 with 0xA5..A5; wr_cnt = 1, rd_cnt = 1.
- Write all-ones to addr 3, then write 0 with wdata_payload_we = 32'h0000_000F, then read addr 3 → low 4 bytes 0, rest 0xFF.
- rdata_ready held low 10 cycles in RESP → rdata_valid and data stable all 10 cycles, cmd_ready 0; completes when rdata_ready rises.
- Read addr 64 (DEPTH = 64) → rdata_payload_data = 0, addr_err = 1 and stays 1 until clr_i.
- clr_i asserted in WDATA in the same cycle as a wdata handshake → no SRAM write (a later read shows old data), state IDLE, counters 0.
- enable = 0 with cmd_valid = 1 → cmd_ready stays 0; command accepted the cycle after enable rises.
